vga_fb_port_arbiter: RTL
========================

Name: vga_fb_port_arbiter

Overview:
- Shares the single-port VGABuffer pixel RAM between two requesters.
- The VGA scanout reader has priority, because it has a hard line deadline.
- The host port (the write path behind the AXI slave) gets a guaranteed slot after a bounded run of scanout grants.
- The block issues RAM commands, tags each read, returns read data to the owning requester, and keeps a host-stall statistic for the register file.

Parameters:
- ADDR_W, 16: pixel RAM address width.
- DATA_W, 12: pixel width (RGB 4:4:4).
- MAX_SCAN_RUN, 4: maximum consecutive scanout grants while the host is waiting.
- WAIT_W, 16: width of the host stall counter.

Ports:
- ACLK  in  1  clock; everything is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- scan_valid  in  1  scanout read request.
- scan_addr  in  ADDR_W  scanout read address.
- scan_ready  out  1  scanout request accepted this cycle.
- scan_rdata  out  DATA_W  scanout read data.
- scan_rvalid  out  1  scan_rdata valid.
- host_valid  in  1  host request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_en with ram_we = 0.
- host_wait_max  out  WAIT_W  longest host stall seen since reset.
- host_clr_stat  in  1  clears host_wait_max.

Behaviour:
- Reset:
  - Every output is 0.
  - run_cnt = 0, wait_cnt = 0, read tag cleared.
  - A read issued in the cycle ARESET is sampled never produces rvalid.
- Handshake:
  - A request is transferred in a cycle where valid && ready.
  - Readies are combinational from the valids and run_cnt.
  - A requester must hold valid, addr and data stable until ready.
- Arbitration, each cycle:
  - Only scan_valid: scan granted.
  - Only host_valid: host granted.
  - Both valid: scan granted if run_cnt < MAX_SCAN_RUN, else host granted.
  - Neither: no grant; ram_en = 0.
  - At most one of scan_ready or host_ready is high in any cycle.
- run_cnt:
  - Increments, saturating at MAX_SCAN_RUN, on each scan grant while host_valid = 1.
  - Clears on a host grant or on any cycle with host_valid = 0.
  - Consequence: at most MAX_SCAN_RUN scan grants occur between host_valid rising and host_ready.
- RAM command:
  - Driven combinationally in the grant cycle: ram_en = 1, ram_addr and ram_we/ram_wdata from the winner.
  - Scan requests always have ram_we = 0.
- Read return:
  - A registered tag {valid, owner} is set in the grant cycle of a read.
  - Next cycle: the owner's rvalid = 1 and its rdata = ram_rdata.
  - Read latency is exactly 1 cycle.
  - Back-to-back reads give back-to-back rvalids.
  - rdata holds its last value when rvalid = 0.
  - Host writes produce no rvalid.
- Ordering: single port, so accesses are strictly in grant order. A host write to A followed next cycle by a scan read of A returns the new data.
- Stall statistic:
  - wait_cnt increments, saturating, each cycle with host_valid && !host_ready.
  - wait_cnt clears on a host grant.
  - On a host grant, host_wait_max <= max(host_wait_max, wait_cnt).
  - host_clr_stat sets host_wait_max to 0 next cycle and takes precedence over a simultaneous update.
- Reset mid-stream: pending requests are dropped and requesters must re-present them. Arbitration restarts with run_cnt = 0.

Test Plan:
- Reset, then idle for 10 cycles -> all outputs 0, ram_en never asserted.
- Host writes 0xABC to addr 0x0010; next cycle scan reads 0x0010 -> scan_rvalid exactly 1 cycle after scan_ready, scan_rdata = 0xABC, host_rvalid stays 0.
- scan_valid held high continuously while the host requests a read of 0x0020 -> exactly 4 scan grants, then host_ready; host_rvalid 1 cycle later; scan resumes the following cycle; host_wait_max = 4.
- Both requesters idle except the host streaming 8 writes -> host_ready high every cycle, 8 consecutive ram_en/ram_we pulses.
- ARESET asserted in the cycle after a scan grant -> scan_rvalid stays 0; after release, run_cnt = 0 (verified by a fresh 4-grant run).
- host_clr_stat pulsed in the same cycle as a host grant with wait_cnt = 3 -> host_wait_max = 0 on the next cycle.

Source files
------------

// File: rtl/vga_fb_port_arbiter.sv
// vga_fb_port_arbiter
// Shares the single-port VGABuffer pixel RAM between the VGA scanout reader
// and the host write path. Scanout normally wins. The host is still
// guaranteed a slot after at most MAX_SCAN_RUN consecutive scanout grants.
// Each read is tagged with its owner so the data returns to that requester
// one cycle later. The block also tracks the longest host stall since reset.
//
// Ports
//   ACLK, ARESET           clock; synchronous active-high reset
//   scan_valid/addr        scanout read request
//   scan_ready             scanout request accepted this cycle
//   scan_rdata/rvalid      scanout read return
//   host_valid/we/addr/    host request (we = 1 write, 0 read)
//     wdata
//   host_ready             host request accepted this cycle
//   host_rdata/rvalid      host read return
//   ram_en/we/addr/wdata   RAM command, driven in the grant cycle
//   ram_rdata              RAM read data, one cycle after a read command
//   host_wait_max          longest host stall seen
//   host_clr_stat          clears host_wait_max
module vga_fb_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 12,
    parameter int MAX_SCAN_RUN = 4,
    parameter int WAIT_W       = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              scan_valid,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_ready,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_rvalid,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [WAIT_W-1:0] host_wait_max,
    input  logic              host_clr_stat
);

    localparam int RUN_W = $clog2(MAX_SCAN_RUN + 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(MAX_SCAN_RUN);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [RUN_W-1:0]  run_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_max_r;
    logic              tag_valid_r;
    logic              tag_host_r;
    logic [DATA_W-1:0] scan_hold_r;
    logic [DATA_W-1:0] host_hold_r;

    logic              scan_grant_s;
    logic              host_grant_s;
    logic              read_grant_s;
    logic              scan_rvalid_s;
    logic              host_rvalid_s;

    // Grant arbitration. Scanout wins unless the host has already waited through a full run.
    always_comb begin
        scan_grant_s = 1'b0;
        host_grant_s = 1'b0;
        if (ARESET) begin
            scan_grant_s = 1'b0;
            host_grant_s = 1'b0;
        end else if (scan_valid && (!host_valid || (run_cnt_r < RUN_LIMIT))) begin
            scan_grant_s = 1'b1;
        end else if (host_valid) begin
            host_grant_s = 1'b1;
        end else begin
            scan_grant_s = 1'b0;
            host_grant_s = 1'b0;
        end
    end

    assign scan_ready   = scan_grant_s;
    assign host_ready   = host_grant_s;
    assign read_grant_s = scan_grant_s || (host_grant_s && !host_we);

    // RAM command comes straight from the winner in its grant cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        if (scan_grant_s) begin
            ram_en   = 1'b1;
            ram_addr = scan_addr;
        end else if (host_grant_s) begin
            ram_en    = 1'b1;
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_we ? host_wdata : {DATA_W{1'b0}};
        end else begin
            ram_en = 1'b0;
        end
    end

    // Read return routing. A tag that is already in flight is masked while reset is asserted.
    always_comb begin
        scan_rvalid_s = 1'b0;
        host_rvalid_s = 1'b0;
        if (ARESET) begin
            scan_rvalid_s = 1'b0;
            host_rvalid_s = 1'b0;
        end else if (tag_valid_r) begin
            scan_rvalid_s = !tag_host_r;
            host_rvalid_s = tag_host_r;
        end else begin
            scan_rvalid_s = 1'b0;
            host_rvalid_s = 1'b0;
        end
    end

    assign scan_rvalid   = scan_rvalid_s;
    assign host_rvalid   = host_rvalid_s;
    assign scan_rdata    = ARESET ? {DATA_W{1'b0}} : (scan_rvalid_s ? ram_rdata : scan_hold_r);
    assign host_rdata    = ARESET ? {DATA_W{1'b0}} : (host_rvalid_s ? ram_rdata : host_hold_r);
    assign host_wait_max = ARESET ? {WAIT_W{1'b0}} : wait_max_r;

    // Consecutive scanout grants taken while the host is waiting.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            run_cnt_r <= {RUN_W{1'b0}};
        end else if (host_grant_s || !host_valid) begin
            run_cnt_r <= {RUN_W{1'b0}};
        end else if (scan_grant_s && (run_cnt_r < RUN_LIMIT)) begin
            run_cnt_r <= run_cnt_r + RUN_ONE;
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Host stall counter. It saturates, and it clears when the host is granted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (host_grant_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (host_valid && (wait_cnt_r != WAIT_SAT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Longest stall. A clear request overrides an update in the same cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wait_max_r <= {WAIT_W{1'b0}};
        end else if (host_clr_stat) begin
            wait_max_r <= {WAIT_W{1'b0}};
        end else if (host_grant_s && (wait_cnt_r > wait_max_r)) begin
            wait_max_r <= wait_cnt_r;
        end else begin
            wait_max_r <= wait_max_r;
        end
    end

    // Read tag {valid, owner} captured in the grant cycle of a read.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tag_valid_r <= 1'b0;
            tag_host_r  <= 1'b0;
        end else begin
            tag_valid_r <= read_grant_s;
            tag_host_r  <= host_grant_s;
        end
    end

    // Last returned data per requester, so rdata stays stable between returns.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            scan_hold_r <= {DATA_W{1'b0}};
            host_hold_r <= {DATA_W{1'b0}};
        end else begin
            scan_hold_r <= scan_rvalid_s ? ram_rdata : scan_hold_r;
            host_hold_r <= host_rvalid_s ? ram_rdata : host_hold_r;
        end
    end

endmodule
